// File: rtl/serial_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Optional even-parity bit is enabled with SERIAL_PATTERN_TX_PARITY_EN.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_e;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_GAP_CYCLES = 2;

  // Even parity of a word; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_pattern_shreg.sv
// Load/shift register with bit counter for the serial pattern transmitter.
// Shifts MSB-first with zero fill; last_bit flags the final shift cycle.
module serial_pattern_shreg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_cnt,
  output logic             msb,
  output logic             last_bit
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: load has priority over shift; counter holds at zero.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (load) begin
      shreg_d = load_data;
      cnt_d   = load_cnt;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign msb      = shreg_q[WIDTH-1];
  assign last_bit = (cnt_q == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a word via valid/ready, shifts it out
// MSB-first on x_out, then forces GAP_CYCLES zero bits before the next word.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit per word.
module serial_pattern_tx
  import serial_pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  localparam logic [CNT_W-1:0] BIT_CNT_LOAD = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] BIT_CNT_LOAD = CNT_W'(WIDTH - 1);
`endif

  state_e     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic       done_q, done_d;
  logic       load, shift_en, msb, last_bit;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic       parity_q;

  // Capture parity of the accepted word; driven out on the extra SHIFT cycle.
  always_ff @(posedge clock) begin
    if (!reset)    parity_q <= 1'b0;
    else if (load) parity_q <= even_parity(32'(data_in));
  end
`endif

  serial_pattern_shreg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .shift_en  (shift_en),
    .load_data (data_in),
    .load_cnt  (BIT_CNT_LOAD),
    .msb       (msb),
    .last_bit  (last_bit)
  );

  // FSM next-state, handshake and output decode.
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    ready_out = 1'b0;
    busy_out  = 1'b0;
    x_out     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy_out = 1'b1;
        shift_en = 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        // Counter reaches zero on the parity cycle, after all data bits.
        x_out    = last_bit ? parity_q : msb;
`else
        x_out    = msb;
`endif
        if (last_bit) begin
          state_d = GAP;
          gap_d   = 4'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        busy_out = 1'b1;
        if (gap_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, gap counter and done pulse registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  assign done_out = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: directed scenarios followed by
// randomized traffic, checked cycle by cycle against a queue-based model of
// the expected serial stream.
module tb_serial_pattern_tx;

  localparam int unsigned W = 8;
  localparam int unsigned G = 2;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_out, x_out, busy_out, done_out;

  int unsigned  checks = 0;
  int unsigned  errors = 0;

  // Expected x_out for the current and upcoming cycles of the word in flight.
  logic         exp_q[$];
  logic         exp_done = 1'b0;

  serial_pattern_tx #(
    .WIDTH      (W),
    .GAP_CYCLES (G)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .x_out     (x_out),
    .busy_out  (busy_out),
    .done_out  (done_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model across the edge,
  // then compare all outputs on the falling edge.
  task automatic step(input logic rst_v, input logic vld_v, input logic [W-1:0] d_v);
    logic accept;
    int   was;
    reset    = rst_v;
    valid_in = vld_v;
    data_in  = d_v;
    accept   = rst_v && vld_v && (exp_q.size() == 0);
    @(posedge clock);
    if (!rst_v) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      was = exp_q.size();
      if (was > 0) void'(exp_q.pop_front());
      exp_done = (was == 1);
      if (accept) begin
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(d_v[i]);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        exp_q.push_back(^d_v);
`endif
        for (int unsigned j = 0; j < G; j++) exp_q.push_back(1'b0);
      end
    end
    @(negedge clock);
    if (exp_q.size() != 0) begin
      chk("x_out",     x_out,     exp_q[0]);
      chk("busy_out",  busy_out,  1'b1);
      chk("ready_out", ready_out, 1'b0);
    end else begin
      chk("x_out",     x_out,     1'b0);
      chk("busy_out",  busy_out,  1'b0);
      chk("ready_out", ready_out, 1'b1);
    end
    chk("done_out", done_out, exp_done);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    @(negedge clock);

    // Reset hold with valid asserted: nothing may be accepted.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF);

    // Single word.
    step(1'b1, 1'b1, 8'b1011_0110);
    idle(W + G + 2);

    // Back-to-back with valid held high.
    step(1'b1, 1'b1, 8'hA5);
    for (int unsigned i = 0; i < W + G + 1; i++) step(1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b0, '0);
    idle(W + G + 1);

    // Valid while busy is ignored.
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b0, 8'h01);
    for (int unsigned i = 0; i < W; i++) step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b0, '0);
    idle(W + G + 2);

    // Reset in the middle of a word, then a clean word.
    step(1'b1, 1'b1, 8'hF0);
    idle(3);
    step(1'b0, 1'b0, '0);
    idle(2);
    step(1'b1, 1'b1, 8'h81);
    idle(W + G + 2);

    // Pattern meant for the downstream sequence detector.
    step(1'b1, 1'b1, 8'b0000_0110);
    idle(W + G + 2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), W'($urandom));
    end
    idle(W + G + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
